reg_bus_arbiter: RTL and testbench

//  Shares the single internal register bus (reg_wr/reg_waddr/reg_wdata/reg_rd/reg_raddr/reg_rdata)

---
 rtl/reg_bus_arbiter.sv | 171 +++++++++++++++++
 tb/tb_reg_bus_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bus_arbiter.sv
// Two-master arbiter for the internal register bus: serialises AXI-Lite (port 0) and DMA sequencer (port 1).
// Define REG_ARB_FIXED_PRIO_EN to replace round-robin with fixed priority (port 0 wins ties).
module reg_bus_arbiter #(
    parameter int AW     = 16,
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic          S_AXI_ACLK,
    input  logic          S_AXI_ARESETN,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_ack,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ack,
    output logic [DW-1:0] m1_rdata,
    output logic          reg_wr,
    output logic [AW-1:0] reg_waddr,
    output logic [DW-1:0] reg_wdata,
    output logic          reg_rd,
    output logic [AW-1:0] reg_raddr,
    input  logic [DW-1:0] reg_rdata,
    output logic          arb_busy,
    output logic          arb_owner
);

    if (RD_LAT < 1 || RD_LAT > 7) begin : g_rd_lat_check
        $error("reg_bus_arbiter: RD_LAT must be within 1..7");
    end

    localparam logic [2:0] RD_LAT_C = 3'(RD_LAT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ACK   = 2'd3
    } state_t;

    state_t        state_r;
    logic          we_r;
    logic [2:0]    cnt_r;
    logic          prio_s;
    logic          win_s;
    logic          any_req_s;
    logic          win_we_s;
    logic [AW-1:0] win_addr_s;
    logic [DW-1:0] win_wdata_s;

`ifdef REG_ARB_FIXED_PRIO_EN
    assign prio_s = 1'b0;
`else
    logic rr_r;
    assign prio_s = rr_r;
`endif

    assign any_req_s = m0_req | m1_req;

    // Winner selection and mux of the winning master's request fields
    always_comb begin
        if (m0_req && m1_req) begin
            win_s = prio_s;
        end else if (m1_req) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
        if (win_s) begin
            win_we_s    = m1_we;
            win_addr_s  = m1_addr;
            win_wdata_s = m1_wdata;
        end else begin
            win_we_s    = m0_we;
            win_addr_s  = m0_addr;
            win_wdata_s = m0_wdata;
        end
    end

    // Access sequencer; strobes are set on the grant edge so they are high exactly in ISSUE
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_r   <= ST_IDLE;
            we_r      <= 1'b0;
            cnt_r     <= 3'd0;
`ifndef REG_ARB_FIXED_PRIO_EN
            rr_r      <= 1'b0;
`endif
            m0_ack    <= 1'b0;
            m1_ack    <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
            reg_wr    <= 1'b0;
            reg_waddr <= '0;
            reg_wdata <= '0;
            reg_rd    <= 1'b0;
            reg_raddr <= '0;
            arb_busy  <= 1'b0;
            arb_owner <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (any_req_s) begin
                        state_r   <= ST_ISSUE;
                        arb_busy  <= 1'b1;
                        arb_owner <= win_s;
                        we_r      <= win_we_s;
                        if (win_we_s) begin
                            reg_wr    <= 1'b1;
                            reg_waddr <= win_addr_s;
                            reg_wdata <= win_wdata_s;
                        end else begin
                            reg_rd    <= 1'b1;
                            reg_raddr <= win_addr_s;
                        end
                    end
                end
                ST_ISSUE: begin
                    reg_wr <= 1'b0;
                    reg_rd <= 1'b0;
                    if (we_r) begin
                        state_r <= ST_ACK;
                        m0_ack  <= ~arb_owner;
                        m1_ack  <= arb_owner;
                    end else begin
                        state_r <= ST_WAIT;
                        cnt_r   <= 3'd1;
                    end
                end
                ST_WAIT: begin
                    if (cnt_r == RD_LAT_C) begin
                        if (arb_owner) begin
                            m1_rdata <= reg_rdata;
                        end else begin
                            m0_rdata <= reg_rdata;
                        end
                        state_r <= ST_ACK;
                        cnt_r   <= 3'd0;
                        m0_ack  <= ~arb_owner;
                        m1_ack  <= arb_owner;
                    end else begin
                        cnt_r <= cnt_r + 3'd1;
                    end
                end
                ST_ACK: begin
                    m0_ack   <= 1'b0;
                    m1_ack   <= 1'b0;
                    arb_busy <= 1'b0;
`ifndef REG_ARB_FIXED_PRIO_EN
                    rr_r     <= ~arb_owner;
`endif
                    state_r  <= ST_IDLE;
                end
                default: begin
                    state_r  <= ST_IDLE;
                    m0_ack   <= 1'b0;
                    m1_ack   <= 1'b0;
                    reg_wr   <= 1'b0;
                    reg_rd   <= 1'b0;
                    arb_busy <= 1'b0;
                    cnt_r    <= 3'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Self-checking bench for reg_bus_arbiter: directed vector table, corner sequences and a
// randomized run against a transaction-level reference model.
module tb_reg_bus_arbiter;
    localparam int LAT  = 1;
    localparam int LAT3 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        m0_req, m0_we, m0_ack, m1_req, m1_we, m1_ack;
    logic [15:0] m0_addr, m1_addr, reg_waddr, reg_raddr;
    logic [31:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, reg_wdata, reg_rdata;
    logic        reg_wr, reg_rd, arb_busy, arb_owner;

    logic        t_m0_req, t_m0_we, t_m0_ack, t_m1_req, t_m1_we, t_m1_ack;
    logic [15:0] t_m0_addr, t_m1_addr, t_reg_waddr, t_reg_raddr;
    logic [31:0] t_m0_wdata, t_m1_wdata, t_m0_rdata, t_m1_rdata, t_reg_wdata, t_reg_rdata;
    logic        t_reg_wr, t_reg_rd, t_arb_busy, t_arb_owner;

    reg_bus_arbiter #(.AW(16), .DW(32), .RD_LAT(LAT)) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .reg_wr(reg_wr), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
        .reg_rd(reg_rd), .reg_raddr(reg_raddr), .reg_rdata(reg_rdata),
        .arb_busy(arb_busy), .arb_owner(arb_owner)
    );

    reg_bus_arbiter #(.AW(16), .DW(32), .RD_LAT(LAT3)) dut3 (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .m0_req(t_m0_req), .m0_we(t_m0_we), .m0_addr(t_m0_addr), .m0_wdata(t_m0_wdata),
        .m0_ack(t_m0_ack), .m0_rdata(t_m0_rdata),
        .m1_req(t_m1_req), .m1_we(t_m1_we), .m1_addr(t_m1_addr), .m1_wdata(t_m1_wdata),
        .m1_ack(t_m1_ack), .m1_rdata(t_m1_rdata),
        .reg_wr(t_reg_wr), .reg_waddr(t_reg_waddr), .reg_wdata(t_reg_wdata),
        .reg_rd(t_reg_rd), .reg_raddr(t_reg_raddr), .reg_rdata(t_reg_rdata),
        .arb_busy(t_arb_busy), .arb_owner(t_arb_owner)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        bit          port;
        bit          we;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdval;
        int          ack_at;
    } vec_t;

    vec_t        vecs[6];
    logic [31:0] exp_rd0, exp_rd1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = 16'h0; m0_wdata = 32'h0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = 16'h0; m1_wdata = 32'h0;
        reg_rdata = 32'h0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) step();
        rst_n = 1'b1;
        step();
        exp_rd0 = 32'h0;
        exp_rd1 = 32'h0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        string nm;
        nm = $sformatf("vec%0d", idx);
        if (v.port) begin
            m1_req = 1'b1; m1_we = v.we; m1_addr = v.addr; m1_wdata = v.wdata;
        end else begin
            m0_req = 1'b1; m0_we = v.we; m0_addr = v.addr; m0_wdata = v.wdata;
        end
        for (int c = 1; c <= v.ack_at + 1; c++) begin
            step();
            if (!v.we && c == 1 + LAT) reg_rdata = v.rdval;
            else reg_rdata = $urandom;
            check({nm, " ctl"}, {58'h0, reg_wr, reg_rd, m0_ack, m1_ack, arb_busy, arb_owner},
                  {58'h0, (c == 1) && v.we, (c == 1) && !v.we,
                   (c == v.ack_at) && !v.port, (c == v.ack_at) && v.port,
                   c <= v.ack_at, v.port});
            if (c == 1) begin
                if (v.we) check({nm, " wbus"}, {16'h0, reg_waddr, reg_wdata}, {16'h0, v.addr, v.wdata});
                else      check({nm, " rbus"}, {48'h0, reg_raddr}, {48'h0, v.addr});
            end
            if (c == v.ack_at) begin
                if (!v.we) begin
                    if (v.port) exp_rd1 = v.rdval;
                    else        exp_rd0 = v.rdval;
                end
                check({nm, " rdata"}, {m0_rdata, m1_rdata}, {exp_rd0, exp_rd1});
            end
            if (c == v.ack_at + 1) begin
                m0_req = 1'b0;
                m1_req = 1'b0;
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic        exp_owner, cur_owner, ok, found;
        int          nstrobe, dual;
        logic        req_a[2], we_a[2], pend_drop[2];
        logic [15:0] addr_a[2];
        logic [31:0] wdata_a[2];
        logic [31:0] bank[16], exp_mem[16];
        logic        mb, mo, mwe, mrr, e_wr, e_rd, e_ack, ack_p, rd_pend;
        logic [15:0] maddr;
        logic [31:0] mwd, mrv, rd_val;
        int          k, ml, rd_cnt;
        logic [31:0] erd[2];

        t_m0_req = 1'b0; t_m0_we = 1'b0; t_m0_addr = 16'h0; t_m0_wdata = 32'h0;
        t_m1_req = 1'b0; t_m1_we = 1'b0; t_m1_addr = 16'h0; t_m1_wdata = 32'h0;
        t_reg_rdata = 32'h0;

        vecs[0] = '{1'b0, 1'b1, 16'h0010, 32'hA5A5_0001, 32'h0000_0000, 2};
        vecs[1] = '{1'b1, 1'b0, 16'h0024, 32'h0000_0000, 32'hDEAD_BEEF, 3};
        vecs[2] = '{1'b1, 1'b1, 16'h0100, 32'h1234_5678, 32'h0000_0000, 2};
        vecs[3] = '{1'b0, 1'b0, 16'h0010, 32'h0000_0000, 32'hCAFE_0001, 3};
        vecs[4] = '{1'b0, 1'b1, 16'hFFFC, 32'hFFFF_FFFF, 32'h0000_0000, 2};
        vecs[5] = '{1'b1, 1'b0, 16'hFFFC, 32'h0000_0000, 32'h0000_0000, 3};

        // Reset state, then asynchronous reset in the middle of a read
        do_reset();
        check("reset ctl", {reg_wr, reg_rd, m0_ack, m1_ack, arb_busy, arb_owner, reg_waddr, reg_raddr},
              {6'b0, 16'h0, 16'h0});
        check("reset rdata", {m0_rdata, m1_rdata}, 64'h0);
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 16'h0024;
        step();
        check("midread strobe", {62'h0, reg_rd, arb_owner}, {62'h0, 1'b1, 1'b1});
        #2 rst_n = 1'b0;
        #1;
        check("async reset", {reg_wr, reg_rd, m0_ack, m1_ack, arb_busy, arb_owner, reg_waddr, reg_raddr},
              {6'b0, 16'h0, 16'h0});
        step();
        step();
        m1_req = 1'b0;
        rst_n = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (m0_ack || m1_ack || arb_busy || reg_rd || reg_wr) ok = 1'b0;
        end
        check("post reset quiet", {63'h0, ok}, 64'h1);

        // Single-port vector table
        do_reset();
        for (int i = 0; i < 6; i++) begin
            run_vec(i, vecs[i]);
            step();
        end

        // RD_LAT=3 read on the second instance
        t_m0_req = 1'b1; t_m0_we = 1'b0; t_m0_addr = 16'h0004;
        for (int c = 1; c <= 6; c++) begin
            step();
            t_reg_rdata = (c == 1 + LAT3) ? 32'h600D_F00D : $urandom;
            check("lat3 ctl", {61'h0, t_reg_rd, t_m0_ack, t_m1_ack}, {61'h0, c == 1, c == 5, 1'b0});
            if (c == 1) check("lat3 raddr", {48'h0, t_reg_raddr}, 64'h0004);
            if (c == 5) check("lat3 rdata", {32'h0, t_m0_rdata}, {32'h0, 32'h600D_F00D});
            if (c == 6) t_m0_req = 1'b0;
        end

        // Both ports writing continuously from reset
        do_reset();
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 16'h0040; m0_wdata = 32'h1000_0000;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 16'h0044; m1_wdata = 32'h2000_0000;
        exp_owner = 1'b0; cur_owner = 1'b0; nstrobe = 0; dual = 0;
        for (int c = 1; c <= 36; c++) begin
            step();
            if (reg_wr || reg_rd) begin
                check("cont grant", {46'h0, reg_rd, arb_owner, reg_waddr},
                      {46'h0, 1'b0, exp_owner, exp_owner ? 16'h0044 : 16'h0040});
                cur_owner = exp_owner;
                nstrobe++;
`ifndef REG_ARB_FIXED_PRIO_EN
                exp_owner = ~exp_owner;
`endif
            end
            if (m0_ack && m1_ack) dual++;
            if (m0_ack || m1_ack) check("cont ack port", {62'h0, m0_ack, m1_ack}, {62'h0, !cur_owner, cur_owner});
            if (m0_ack) m0_wdata = m0_wdata + 32'h1;
            if (m1_ack) m1_wdata = m1_wdata + 32'h1;
        end
        check("cont strobes", 64'(nstrobe), 64'd12);
        check("cont dual ack", 64'(dual), 64'd0);
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            step();
            if (m0_ack) found = 1'b1;
        end
        step();
        m0_req = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            step();
            if (reg_wr) begin
                found = 1'b1;
                check("m1 after m0 drop", {63'h0, arb_owner}, 64'h1);
            end
        end
        check("m1 granted in time", {63'h0, found}, 64'h1);
        step();
        step();
        m1_req = 1'b0;

        // Randomized run against the transaction-level model
        do_reset();
        for (int i = 0; i < 16; i++) begin
            bank[i]    = 32'h1000_0000 + 32'(i);
            exp_mem[i] = 32'h1000_0000 + 32'(i);
        end
        for (int p = 0; p < 2; p++) begin
            req_a[p] = 1'b0; we_a[p] = 1'b0; addr_a[p] = 16'h0; wdata_a[p] = 32'h0; pend_drop[p] = 1'b0;
            erd[p] = 32'h0;
        end
        mb = 1'b0; mo = 1'b0; mwe = 1'b0; mrr = 1'b0; maddr = 16'h0; mwd = 32'h0; mrv = 32'h0;
        k = 0; ml = 0; rd_cnt = 0; rd_pend = 1'b0; rd_val = 32'h0;
        for (int cyc = 0; cyc < 900; cyc++) begin
            step();
            if (mb) begin
                k++;
                if (k == ml) mb = 1'b0;
            end else if (req_a[0] || req_a[1]) begin
`ifdef REG_ARB_FIXED_PRIO_EN
                mo = (req_a[0] && req_a[1]) ? 1'b0 : req_a[1];
`else
                mo = (req_a[0] && req_a[1]) ? mrr : req_a[1];
`endif
                mb = 1'b1; k = 0;
                mwe = we_a[mo]; maddr = addr_a[mo]; mwd = wdata_a[mo];
                ml = mwe ? 2 : 2 + LAT;
                if (mwe) exp_mem[maddr[5:2]] = mwd;
                else     mrv = exp_mem[maddr[5:2]];
            end
            e_wr  = mb && (k == 0) && mwe;
            e_rd  = mb && (k == 0) && !mwe;
            e_ack = mb && (k == ml - 1);
            if (e_ack) begin
                mrr = ~mo;
                if (!mwe) erd[mo] = mrv;
            end
            check("rand ctl", {58'h0, reg_wr, reg_rd, m0_ack, m1_ack, arb_busy, arb_owner},
                  {58'h0, e_wr, e_rd, e_ack && !mo, e_ack && mo, mb, mo});
            check("rand rdata", {m0_rdata, m1_rdata}, {erd[0], erd[1]});
            if (e_wr) check("rand wbus", {16'h0, reg_waddr, reg_wdata}, {16'h0, maddr, mwd});
            if (e_rd) check("rand rbus", {48'h0, reg_raddr}, {48'h0, maddr});

            if (reg_wr) bank[reg_waddr[5:2]] = reg_wdata;
            if (rd_pend) rd_cnt--;
            if (reg_rd) begin
                rd_pend = 1'b1; rd_cnt = LAT; rd_val = bank[reg_raddr[5:2]];
            end
            if (rd_pend && rd_cnt == 0) begin
                reg_rdata = rd_val; rd_pend = 1'b0;
            end else begin
                reg_rdata = $urandom;
            end

            for (int p = 0; p < 2; p++) begin
                ack_p = (p == 1) ? m1_ack : m0_ack;
                if (pend_drop[p]) begin
                    req_a[p] = 1'b0; pend_drop[p] = 1'b0;
                end else if (req_a[p] && ack_p) begin
                    pend_drop[p] = 1'b1;
                end else if (!req_a[p] && $urandom_range(0, 2) == 0) begin
                    req_a[p]   = 1'b1;
                    we_a[p]    = 1'($urandom_range(0, 1));
                    addr_a[p]  = {10'h0, 4'($urandom_range(0, 15)), 2'b00};
                    wdata_a[p] = $urandom;
                end
            end
            m0_req = req_a[0]; m0_we = we_a[0]; m0_addr = addr_a[0]; m0_wdata = wdata_a[0];
            m1_req = req_a[1]; m1_we = we_a[1]; m1_addr = addr_a[1]; m1_wdata = wdata_a[1];
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
